// File: rtl/agusec_chk_pipe.sv
// Resolves capability AGU bounds-check results into registered pass/fault entries,
// queues them toward the LSQ and holds the first fault. Optional counter: AGUSEC_FAULT_CNT_EN.
module agusec_chk_pipe #(
   parameter int ROBW = 9,
   parameter int CNTW = 16,
   parameter int QD   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_en,
   output logic            in_rdy,
   input  logic [64:0]     in_ptr,
   input  logic [43:0]     in_addr,
   input  logic            in_neg,
   input  logic [1:0]      in_c,
   input  logic [3:0]      in_pos_ack,
   input  logic [3:0]      in_neg_ack,
   input  logic            in_secq,
   input  logic [ROBW-1:0] in_rob,
   input  logic            in_flush,
   output logic            out_en,
   input  logic            out_rdy,
   output logic [43:0]     out_addr,
   output logic [ROBW-1:0] out_rob,
   output logic            out_fault,
   output logic [1:0]      out_code,
   output logic            flt_vld,
   output logic [ROBW-1:0] flt_rob,
   output logic [1:0]      flt_code,
   output logic [43:0]     flt_addr,
   input  logic            flt_clr,
   output logic [CNTW-1:0] flt_cnt
);

   localparam int AW = (QD > 1) ? $clog2(QD) : 1;
   localparam int CW = AW + 1;

   // Only the tag bit of the pointer matters here.
   logic unused_ptr_bits;
   assign unused_ptr_bits = ^in_ptr[63:0];

   logic            s1_v_q, s1_v_d;
   logic            s1_tag_q, s1_tag_d;
   logic            s1_up_ok_q, s1_up_ok_d;
   logic            s1_secq_q, s1_secq_d;
   logic [43:0]     s1_addr_q, s1_addr_d;
   logic [ROBW-1:0] s1_rob_q, s1_rob_d;

   logic            s2_v_q, s2_v_d;
   logic [1:0]      s2_code_q, s2_code_d;
   logic [43:0]     s2_addr_q, s2_addr_d;
   logic [ROBW-1:0] s2_rob_q, s2_rob_d;

   logic [43:0]     mem_addr_q [QD];
   logic [43:0]     mem_addr_d [QD];
   logic [ROBW-1:0] mem_rob_q  [QD];
   logic [ROBW-1:0] mem_rob_d  [QD];
   logic [1:0]      mem_code_q [QD];
   logic [1:0]      mem_code_d [QD];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            flt_vld_q, flt_vld_d;
   logic [ROBW-1:0] flt_rob_q, flt_rob_d;
   logic [1:0]      flt_code_q, flt_code_d;
   logic [43:0]     flt_addr_q, flt_addr_d;

   logic            accept, enq, deq, flt_enq, flt_take;
   logic [CW:0]     occ;

   // Space is reserved for everything already in S1/S2, so the queue cannot overflow.
   always_comb begin
      occ    = (CW+1)'(count_q) + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
      in_rdy = (occ <= (CW+1)'(QD - 1));
   end

   assign accept  = in_en & in_rdy & ~in_flush;
   assign enq     = s2_v_q & ~in_flush;
   assign deq     = out_en & out_rdy & ~in_flush;
   assign flt_enq = enq & (s2_code_q != 2'd0);
   assign flt_take = flt_enq & (~flt_vld_q | flt_clr);

   // Stage 1: capture tag, selected upper ack and range result.
   always_comb begin
      s1_v_d     = accept;
      s1_tag_d   = s1_tag_q;
      s1_up_ok_d = s1_up_ok_q;
      s1_secq_d  = s1_secq_q;
      s1_addr_d  = s1_addr_q;
      s1_rob_d   = s1_rob_q;
      if (accept) begin
         s1_tag_d   = in_ptr[64];
         s1_up_ok_d = in_neg ? in_neg_ack[in_c] : in_pos_ack[in_c];
         s1_secq_d  = in_secq;
         s1_addr_d  = in_addr;
         s1_rob_d   = in_rob;
      end
   end

   // Stage 2: prioritised fault code.
   always_comb begin
      s2_v_d    = s1_v_q & ~in_flush;
      s2_code_d = s2_code_q;
      s2_addr_d = s2_addr_q;
      s2_rob_d  = s2_rob_q;
      if (s1_v_q) begin
         if (!s1_tag_q)        s2_code_d = 2'd1;
         else if (!s1_up_ok_q) s2_code_d = 2'd2;
         else if (!s1_secq_q)  s2_code_d = 2'd3;
         else                  s2_code_d = 2'd0;
         s2_addr_d = s1_addr_q;
         s2_rob_d  = s1_rob_q;
      end
   end

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_rob_d  = mem_rob_q;
      mem_code_d = mem_code_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CW'(enq) - CW'(deq);
      if (enq) begin
         mem_addr_d[wr_ptr_q] = s2_addr_q;
         mem_rob_d[wr_ptr_q]  = s2_rob_q;
         mem_code_d[wr_ptr_q] = s2_code_q;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (in_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      flt_vld_d  = flt_vld_q;
      flt_rob_d  = flt_rob_q;
      flt_code_d = flt_code_q;
      flt_addr_d = flt_addr_q;
      if (flt_take) begin
         flt_vld_d  = 1'b1;
         flt_rob_d  = s2_rob_q;
         flt_code_d = s2_code_q;
         flt_addr_d = s2_addr_q;
      end else if (flt_clr) begin
         flt_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flt_vld_q  <= 1'b0;
         flt_rob_q  <= '0;
         flt_code_q <= '0;
         flt_addr_q <= '0;
      end else begin
         s1_v_q     <= s1_v_d;
         s2_v_q     <= s2_v_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flt_vld_q  <= flt_vld_d;
         flt_rob_q  <= flt_rob_d;
         flt_code_q <= flt_code_d;
         flt_addr_q <= flt_addr_d;
      end
   end

   // Datapath registers carry no reset; their valids qualify them.
   always_ff @(posedge clk) begin
      s1_tag_q   <= s1_tag_d;
      s1_up_ok_q <= s1_up_ok_d;
      s1_secq_q  <= s1_secq_d;
      s1_addr_q  <= s1_addr_d;
      s1_rob_q   <= s1_rob_d;
      s2_code_q  <= s2_code_d;
      s2_addr_q  <= s2_addr_d;
      s2_rob_q   <= s2_rob_d;
      mem_addr_q <= mem_addr_d;
      mem_rob_q  <= mem_rob_d;
      mem_code_q <= mem_code_d;
   end

   // Head fields are forced to zero when empty so reset and flush show clean outputs.
   always_comb begin
      out_en    = (count_q != '0);
      out_addr  = out_en ? mem_addr_q[rd_ptr_q] : '0;
      out_rob   = out_en ? mem_rob_q[rd_ptr_q]  : '0;
      out_code  = out_en ? mem_code_q[rd_ptr_q] : '0;
      out_fault = out_en & (out_code != 2'd0);
   end

   assign flt_vld  = flt_vld_q;
   assign flt_rob  = flt_rob_q;
   assign flt_code = flt_code_q;
   assign flt_addr = flt_addr_q;

`ifdef AGUSEC_FAULT_CNT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flt_enq && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign flt_cnt = cnt_q;
`else
   assign flt_cnt = '0;
`endif

endmodule

// File: tb/tb_agusec_chk_pipe.sv
// Directed scoreboard bench for agusec_chk_pipe; counter checks follow AGUSEC_FAULT_CNT_EN.
module tb_agusec_chk_pipe;

   localparam int ROBW = 9;
   localparam int CNTW = 16;
   localparam int QD   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_en, in_rdy;
   logic [64:0]     in_ptr;
   logic [43:0]     in_addr;
   logic            in_neg;
   logic [1:0]      in_c;
   logic [3:0]      in_pos_ack, in_neg_ack;
   logic            in_secq;
   logic [ROBW-1:0] in_rob;
   logic            in_flush;
   logic            out_en, out_rdy;
   logic [43:0]     out_addr;
   logic [ROBW-1:0] out_rob;
   logic            out_fault;
   logic [1:0]      out_code;
   logic            flt_vld;
   logic [ROBW-1:0] flt_rob;
   logic [1:0]      flt_code;
   logic [43:0]     flt_addr;
   logic            flt_clr;
   logic [CNTW-1:0] flt_cnt;

   agusec_chk_pipe #(.ROBW(ROBW), .CNTW(CNTW), .QD(QD)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .in_rdy(in_rdy), .in_ptr(in_ptr),
      .in_addr(in_addr), .in_neg(in_neg), .in_c(in_c), .in_pos_ack(in_pos_ack),
      .in_neg_ack(in_neg_ack), .in_secq(in_secq), .in_rob(in_rob), .in_flush(in_flush),
      .out_en(out_en), .out_rdy(out_rdy), .out_addr(out_addr), .out_rob(out_rob),
      .out_fault(out_fault), .out_code(out_code), .flt_vld(flt_vld), .flt_rob(flt_rob),
      .flt_code(flt_code), .flt_addr(flt_addr), .flt_clr(flt_clr), .flt_cnt(flt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [43:0]     addr;
      logic [ROBW-1:0] rob;
      logic [1:0]      code;
   } exp_t;

   exp_t            sb[$];
   int              total = 0;
   int              bad   = 0;
   int              n_acc = 0;
   logic [CNTW-1:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] code_of(input logic tag, input logic neg, input logic [1:0] c,
                                          input logic [3:0] pa, input logic [3:0] na,
                                          input logic secq);
      logic up;
      up = neg ? na[c] : pa[c];
      if (!tag)     return 2'd1;
      else if (!up) return 2'd2;
      else if (!secq) return 2'd3;
      return 2'd0;
   endfunction

   task automatic drive(input logic tag, input logic neg, input logic [1:0] c, input logic [3:0] pa,
                        input logic [3:0] na, input logic secq, input logic [43:0] addr,
                        input logic [ROBW-1:0] rob);
      in_en      = 1'b1;
      in_ptr     = {tag, 64'hdead_beef_0000_0000 | 64'(rob)};
      in_neg     = neg;
      in_c       = c;
      in_pos_ack = pa;
      in_neg_ack = na;
      in_secq    = secq;
      in_addr    = addr;
      in_rob     = rob;
   endtask

   // One clock: account for both handshakes with the values driven for this cycle, then advance.
   task automatic step();
      bit   acc, deq;
      exp_t e;
      acc = rst && !in_flush && in_en && in_rdy;
      deq = rst && !in_flush && out_en && out_rdy;
      if (deq) begin
         if (sb.size() == 0) chk("sb_extra", 64'(out_rob), 64'hffff);
         else begin
            e = sb.pop_front();
            chk("sb_addr", 64'(out_addr), 64'(e.addr));
            chk("sb_rob", 64'(out_rob), 64'(e.rob));
            chk("sb_code", 64'(out_code), 64'(e.code));
            chk("sb_fault", 64'(out_fault), 64'(e.code != 2'd0));
         end
      end
      if (acc) begin
         e.addr = in_addr;
         e.rob  = in_rob;
         e.code = code_of(in_ptr[64], in_neg, in_c, in_pos_ack, in_neg_ack, in_secq);
         sb.push_back(e);
         n_acc++;
         if (e.code != 2'd0 && exp_cnt != {CNTW{1'b1}}) exp_cnt++;
      end
      if (!rst || in_flush) sb.delete();
      if (!rst) exp_cnt = '0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_en = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_en = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_out_en"}, 64'(out_en), 64'd0);
      chk({pfx, "_out_fault"}, 64'(out_fault), 64'd0);
      chk({pfx, "_out_code"}, 64'(out_code), 64'd0);
      chk({pfx, "_out_addr"}, 64'(out_addr), 64'd0);
      chk({pfx, "_out_rob"}, 64'(out_rob), 64'd0);
      chk({pfx, "_flt_vld"}, 64'(flt_vld), 64'd0);
      chk({pfx, "_flt_rob"}, 64'(flt_rob), 64'd0);
      chk({pfx, "_flt_code"}, 64'(flt_code), 64'd0);
      chk({pfx, "_flt_addr"}, 64'(flt_addr), 64'd0);
      chk({pfx, "_flt_cnt"}, 64'(flt_cnt), 64'd0);
      chk({pfx, "_in_rdy"}, 64'(in_rdy), 64'd1);
   endtask

   function automatic logic [CNTW-1:0] cnt_exp(input logic [CNTW-1:0] v);
`ifdef AGUSEC_FAULT_CNT_EN
      return v;
`else
      return (v & '0);
`endif
   endfunction

   initial begin
      rst = 1'b0; in_en = 1'b0; in_ptr = '0; in_addr = '0; in_neg = 1'b0; in_c = '0;
      in_pos_ack = '0; in_neg_ack = '0; in_secq = 1'b0; in_rob = '0; in_flush = 1'b0;
      out_rdy = 1'b1; flt_clr = 1'b0;
      @(negedge clk);
      do_reset();
      chk_reset_vals("rst");

      // Single passing access and its latency.
      drive(1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000, 1'b1, 44'h123, 9'd1);
      step();
      in_en = 1'b0;
      chk("lat_p0", 64'(out_en), 64'd0);
      step();
      chk("lat_p1", 64'(out_en), 64'd0);
      step();
      chk("lat_p2", 64'(out_en), 64'd1);
      chk("first_addr", 64'(out_addr), 64'h123);
      chk("first_code", 64'(out_code), 64'd0);
      chk("first_fault", 64'(out_fault), 64'd0);
      idle(2);

      // Fault code priorities.
      drive(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 44'h200, 9'd2);
      step();
      drive(1'b1, 1'b1, 2'd1, 4'b1111, 4'b1101, 1'b0, 44'h300, 9'd3);
      step();
      drive(1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000, 1'b0, 44'h400, 9'd4);
      step();
      idle(5);
      chk("codes_drained", 64'(sb.size()), 64'd0);
      chk("codes_out_en", 64'(out_en), 64'd0);

      // Backpressure: only QD accesses fit.
      out_rdy = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, 2'(k), 4'b1111, 4'b0000, 1'b1, 44'h1000 + 44'(k), 9'(40 + k));
         step();
      end
      chk("bp_accepted", 64'(n_acc), 64'(QD));
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      in_en = 1'b0;
      out_rdy = 1'b1;
      idle(6);
      chk("bp_drained", 64'(sb.size()), 64'd0);
      chk("bp_out_en", 64'(out_en), 64'd0);

      // Fault record: first fault held, clear coincident with a new fault reloads it.
      do_reset();
      drive(1'b0, 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 44'h505, 9'd5);
      step();
      drive(1'b1, 1'b0, 2'd3, 4'b0111, 4'b1111, 1'b1, 44'h909, 9'd9);
      step();
      idle(4);
      chk("rec_vld", 64'(flt_vld), 64'd1);
      chk("rec_rob5", 64'(flt_rob), 64'd5);
      chk("rec_code5", 64'(flt_code), 64'd1);
      chk("rec_addr5", 64'(flt_addr), 64'h505);
      drive(1'b1, 1'b0, 2'd0, 4'b1111, 4'b1111, 1'b0, 44'hc0c, 9'd12);
      step();
      in_en = 1'b0;
      step();
      flt_clr = 1'b1;
      step();
      flt_clr = 1'b0;
      chk("reclr_vld", 64'(flt_vld), 64'd1);
      chk("reclr_rob12", 64'(flt_rob), 64'd12);
      chk("reclr_code3", 64'(flt_code), 64'd3);
      chk("rec_cnt", 64'(flt_cnt), 64'(cnt_exp(16'd3)));
      chk("rec_cnt_model", 64'(flt_cnt), 64'(cnt_exp(exp_cnt)));
      idle(2);

      // Flush with three queued entries and an access on the same cycle.
      out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b1, 44'h2000 + 44'(k), 9'(20 + k));
         step();
      end
      idle(2);
      chk("fl_pre_out_en", 64'(out_en), 64'd1);
      in_flush = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 44'h2fff, 9'd30);
      step();
      in_flush = 1'b0;
      in_en = 1'b0;
      chk("fl_out_en", 64'(out_en), 64'd0);
      chk("fl_in_rdy", 64'(in_rdy), 64'd1);
      chk("fl_flt_vld", 64'(flt_vld), 64'd1);
      chk("fl_flt_rob", 64'(flt_rob), 64'd12);
      chk("fl_flt_cnt", 64'(flt_cnt), 64'(cnt_exp(16'd3)));
      out_rdy = 1'b1;
      idle(3);
      chk("fl_dropped", 64'(out_en), 64'd0);

      // Clear with no new fault: valid drops, fields retained.
      flt_clr = 1'b1;
      step();
      flt_clr = 1'b0;
      chk("clr_vld", 64'(flt_vld), 64'd0);
      chk("clr_rob_kept", 64'(flt_rob), 64'd12);
      chk("clr_addr_kept", 64'(flt_addr), 64'hc0c);

      // Reset mid-stream with a full queue and a held fault.
      out_rdy = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 44'h3000 + 44'(k), 9'(60 + k));
         step();
      end
      idle(2);
      chk("mid_out_en", 64'(out_en), 64'd1);
      chk("mid_flt_vld", 64'(flt_vld), 64'd1);
      chk("mid_in_rdy", 64'(in_rdy), 64'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk_reset_vals("mid_rst");
      out_rdy = 1'b1;

`ifdef AGUSEC_FAULT_CNT_EN
      // Saturation: more faults than the counter can hold.
      for (int k = 0; k < (1 << CNTW) + 5; k++) begin
         drive(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 44'(k), 9'(k));
         step();
      end
      idle(4);
      chk("sat_cnt", 64'(flt_cnt), 64'({CNTW{1'b1}}));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
